// File: rtl/lstm_gate_mac_if.sv
// Valid/ready bundle between the operand feeder, the gate MAC and the activation stage.
interface lstm_gate_mac_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] w;
   logic [WIDTH-1:0] b;
   logic             o_valid;
   logic             o_ready;
   logic [WIDTH-1:0] z;
   logic             sat;

   modport master (output in_valid, x, w, b, o_ready,
                   input  in_ready, o_valid, z, sat);
   modport slave  (input  in_valid, x, w, b, o_ready,
                   output in_ready, o_valid, z, sat);
endinterface

// File: rtl/lstm_gate_mac.sv
// LSTM gate pre-activation: z = sat(floor(sum(x*w) + b)) in Q12.20, one pair per accepted cycle.
module lstm_gate_mac #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 20,
   parameter int NIN   = 8
) (
   input logic clk,
   input logic rst,
   lstm_gate_mac_if.slave bus
);
   localparam int AW = 2*WIDTH + 8;
   localparam int CW = (NIN > 1) ? $clog2(NIN) : 1;

   typedef enum logic [1:0] {ACC, FIN, OUT} state_t;

   state_t                  state;
   logic signed [AW-1:0]    acc;
   logic signed [WIDTH-1:0] breg;
   logic [CW-1:0]           cnt;
   logic [WIDTH-1:0]        z_q;
   logic                    sat_q;
   logic                    o_valid_q;

   logic signed [2*WIDTH-1:0] prod;
   logic signed [AW-1:0]      prod_ext, bias_ext, s, r;
   logic                      accept, last;

   localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   assign bus.in_ready = (state == ACC) && !rst;
   assign bus.o_valid  = o_valid_q;
   assign bus.z        = z_q;
   assign bus.sat      = sat_q;

   assign accept   = bus.in_valid && bus.in_ready;
   assign last     = (cnt == CW'(NIN-1));
   assign prod     = $signed(bus.x) * $signed(bus.w);
   assign prod_ext = {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
   // Bias is aligned to the Q40 product scale before the final floor shift.
   assign bias_ext = {{(AW-WIDTH){breg[WIDTH-1]}}, breg} <<< FRAC;
   assign s        = acc + bias_ext;
   assign r        = s >>> FRAC;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACC;
         acc       <= '0;
         breg      <= '0;
         cnt       <= '0;
         z_q       <= '0;
         sat_q     <= 1'b0;
         o_valid_q <= 1'b0;
      end else begin
         case (state)
            ACC: if (accept) begin
               acc <= acc + prod_ext;
               if (cnt == '0) breg <= $signed(bus.b);
               if (last) begin
                  cnt   <= '0;
                  state <= FIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIN: begin
               if (r > MAXV) begin
                  z_q   <= {1'b0, {(WIDTH-1){1'b1}}};
                  sat_q <= 1'b1;
               end else if (r < MINV) begin
                  z_q   <= {1'b1, {(WIDTH-1){1'b0}}};
                  sat_q <= 1'b1;
               end else begin
                  z_q   <= r[WIDTH-1:0];
                  sat_q <= 1'b0;
               end
               o_valid_q <= 1'b1;
               state     <= OUT;
            end
            OUT: if (bus.o_ready) begin
               o_valid_q <= 1'b0;
               acc       <= '0;
               state     <= ACC;
            end
            default: state <= ACC;
         endcase
      end
   end
endmodule

// File: tb/tb_lstm_gate_mac.sv
// Directed bench for lstm_gate_mac with NIN=4 and hand-computed Q12.20 results.
module tb_lstm_gate_mac;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   lstm_gate_mac_if #(.WIDTH(32)) bus ();
   lstm_gate_mac #(.WIDTH(32), .FRAC(20), .NIN(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Offer one pair until accepted; returns at accept edge + #1.
   task automatic push(input logic [31:0] xv, input logic [31:0] wv, input logic [31:0] bv,
                       output bit tmo);
      int t = 0;
      tmo = 0;
      bus.in_valid = 1'b1; bus.x = xv; bus.w = wv; bus.b = bv;
      while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) tmo = 1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Feed 4 pairs (optionally with idle gaps), return result without consuming it.
   task automatic run_dot(input logic [31:0] xs [4], input logic [31:0] ws [4],
                          input logic [31:0] bv, input bit gaps,
                          output logic [31:0] zo, output logic so,
                          output bit lat_ok, output bit tmo);
      bit t1;
      tmo = 0;
      for (int i = 0; i < 4; i++) begin
         push(xs[i], ws[i], bv, t1);
         tmo |= t1;
         if (gaps && i < 3) begin @(posedge clk); #1; end
      end
      lat_ok = (bus.o_valid === 1'b0);
      @(posedge clk); #1;
      lat_ok &= (bus.o_valid === 1'b1);
      zo = bus.z; so = bus.sat;
   endtask

   task automatic consume(output bit ok);
      bus.o_ready = 1'b1;
      @(posedge clk); #1;
      bus.o_ready = 1'b0;
      ok = (bus.o_valid === 1'b0) && (bus.in_ready === 1'b1);
   endtask

   task automatic check_result(input string name, input logic [31:0] zo, input logic so,
                               input bit lat_ok, input bit tmo,
                               input logic [31:0] ze, input logic se);
      vectors++;
      if (tmo || !lat_ok || zo !== ze || so !== se) begin
         miscompares++;
         $display("FAIL %s: z=%h sat=%b lat_ok=%0d tmo=%0d, expected z=%h sat=%b lat_ok=1 tmo=0",
                  name, zo, so, lat_ok, tmo, ze, se);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.z !== 32'h0 || bus.sat !== 1'b0 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: o_valid=%b z=%h sat=%b in_ready=%b, expected 0/0/0/0",
                  bus.o_valid, bus.z, bus.sat, bus.in_ready);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: in_ready=%b o_valid=%b, expected 1/0", bus.in_ready, bus.o_valid);
      end
   endtask

   task automatic test_dot(input string name, input logic [31:0] xs [4], input logic [31:0] ws [4],
                           input logic [31:0] bv, input bit gaps,
                           input logic [31:0] ze, input logic se);
      logic [31:0] zo; logic so; bit lat_ok, tmo, ok;
      run_dot(xs, ws, bv, gaps, zo, so, lat_ok, tmo);
      check_result(name, zo, so, lat_ok, tmo, ze, se);
      consume(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s_handshake: o_valid=%b in_ready=%b, expected 0/1", name, bus.o_valid, bus.in_ready);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] xs [4], ws [4], zo; logic so; bit lat_ok, tmo, ok, stable;
      xs = '{4{32'h00100000}}; ws = '{4{32'h00080000}};
      run_dot(xs, ws, 32'h00040000, 1'b1, zo, so, lat_ok, tmo);
      check_result("gaps_sum", zo, so, lat_ok, tmo, 32'h00240000, 1'b0);
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1; bus.x = 32'h00100000 + i; bus.w = 32'h00300000 - i; bus.b = 32'h00500000;
         @(posedge clk); #1;
         if (bus.z !== 32'h00240000 || bus.sat !== 1'b0 || bus.o_valid !== 1'b1 || bus.in_ready !== 1'b0)
            stable = 0;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (!stable) begin
         miscompares++;
         $display("FAIL stall_hold: z=%h sat=%b o_valid=%b in_ready=%b, expected 00240000/0/1/0",
                  bus.z, bus.sat, bus.o_valid, bus.in_ready);
      end
      consume(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL stall_handshake: o_valid=%b in_ready=%b, expected 0/1", bus.o_valid, bus.in_ready);
      end
      xs = '{4{32'hFFF00000}}; ws = '{4{32'h00040000}};
      test_dot("after_stall", xs, ws, 32'h0, 1'b0, 32'hFFF00000, 1'b0);
   endtask

   task automatic test_reset_mid;
      logic [31:0] xs [4], ws [4]; bit t1, t2;
      push(32'h00100000, 32'h00080000, 32'h00040000, t1);
      push(32'h00100000, 32'h00080000, 32'h00040000, t2);
      rst = 1'b1;
      #1;
      vectors++;
      if (t1 || t2 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_ready: in_ready=%b tmo=%0d, expected 0 tmo=0", bus.in_ready, t1 | t2);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_after: o_valid=%b in_ready=%b, expected 0/1", bus.o_valid, bus.in_ready);
      end
      xs = '{4{32'h00100000}}; ws = '{4{32'h00080000}};
      test_dot("rst_mid_sum", xs, ws, 32'h00040000, 1'b0, 32'h00240000, 1'b0);
   endtask

   initial begin
      logic [31:0] xs [4], ws [4];
      bus.in_valid = 1'b0; bus.x = '0; bus.w = '0; bus.b = '0; bus.o_ready = 1'b0;
      test_reset();
      xs = '{4{32'h00100000}}; ws = '{4{32'h00080000}};
      test_dot("basic_sum", xs, ws, 32'h00040000, 1'b0, 32'h00240000, 1'b0);
      xs = '{4{32'hFFF00000}}; ws = '{4{32'h00040000}};
      test_dot("negative_sum", xs, ws, 32'h0, 1'b0, 32'hFFF00000, 1'b0);
      xs = '{32'h00000001, 32'h0, 32'h0, 32'h0}; ws = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
      test_dot("floor", xs, ws, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0);
      xs = '{4{32'h7FFFFFFF}}; ws = '{4{32'h7FFFFFFF}};
      test_dot("sat_pos", xs, ws, 32'h0, 1'b0, 32'h7FFFFFFF, 1'b1);
      xs = '{4{32'h7FFFFFFF}}; ws = '{4{32'h80000000}};
      test_dot("sat_neg", xs, ws, 32'h0, 1'b0, 32'h80000000, 1'b1);
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
